// File: rtl/disp7_pkg.sv
// Shared definitions for the 7-segment display scanner: digit geometry,
// cathode bit positions, common glyphs and the scan FSM state type.
package disp7_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int SEG_W      = 8;

   // Bit positions inside one digit pattern {DP,G,F,E,D,C,B,A}
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Glyphs produced by the upstream comparator logic (1 = segment lit)
   localparam logic [SEG_W-1:0] SEG_GT  = 8'h4C;
   localparam logic [SEG_W-1:0] SEG_LT  = 8'h58;
   localparam logic [SEG_W-1:0] SEG_EQ  = 8'h48;
   localparam logic [SEG_W-1:0] SEG_OFF = 8'h00;

   typedef enum logic {
      ACTIVE = 1'b0,
      BLANK  = 1'b1
   } scan_state_t;

   // Largest of three values, used to size the shared duration counter
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/display7seg_scanner_scan_timer.sv
// scan_timer: free-running duration counter. It counts 0..last and pulses tc
// on the final count, restarting at 0 so the next phase begins cleanly.
module scan_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] last,
   output logic         tc
);

   logic [W-1:0] cnt_reg;

   assign tc = (cnt_reg == last);

   // Count up, wrap to zero on terminal count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (tc) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/display7seg_scanner.sv
// display7seg_scanner: double-buffered, time-multiplexed driver for a 4-digit
// common-anode display. Frames are loaded into a shadow buffer and only copied
// to the active buffer at a frame boundary, so a frame is never torn mid-scan.
module display7seg_scanner
   import disp7_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        load_valid,
   output logic                        load_ready,
   input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
   input  logic [NUM_DIGITS-1:0]       en_mask,
   output logic                        frame_done,
   output logic [NUM_DIGITS-1:0]       AN,
   output logic                        CA,
   output logic                        CB,
   output logic                        CC,
   output logic                        CD,
   output logic                        CE,
   output logic                        CF,
   output logic                        CG,
   output logic                        DP
);

   localparam int CNT_W = $clog2(max3(REFRESH_DIV, BLANK_CYCLES, 2));
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] ACTIVE_LAST = CNT_W'(REFRESH_DIV - 1);
   // A zero-length gap still needs one cycle in BLANK only right after reset
   localparam logic [CNT_W-1:0] BLANK_LAST  = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

   scan_state_t                      state_reg;
   scan_state_t                      state_next;
   logic [IDX_W-1:0]                 idx_reg;
   logic                             step;
   logic                             boundary;
   logic                             accept;
   logic                             tc;
   logic [CNT_W-1:0]                 timer_last;
   logic [NUM_DIGITS-1:0][SEG_W-1:0] shadow_seg_reg;
   logic [NUM_DIGITS-1:0][SEG_W-1:0] active_seg_reg;
   logic [NUM_DIGITS-1:0]            shadow_en_reg;
   logic [NUM_DIGITS-1:0]            active_en_reg;
   logic                             pending_reg;
   logic                             frame_done_reg;
   logic [NUM_DIGITS-1:0]            an_sel;
   logic [NUM_DIGITS-1:0]            an_next;
   logic [NUM_DIGITS-1:0]            an_reg;
   logic [SEG_W-1:0]                 seg_next;
   logic [SEG_W-1:0]                 seg_reg;

   assign timer_last = (state_reg == ACTIVE) ? ACTIVE_LAST : BLANK_LAST;

   scan_timer #(.W(CNT_W)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .last  (timer_last),
      .tc    (tc)
   );

   assign load_ready = !pending_reg;
   assign accept     = load_valid && !pending_reg;
   // Wrapping idx from the last digit back to 0 is the frame boundary
   assign boundary   = step && (idx_reg == IDX_W'(NUM_DIGITS - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= BLANK;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; step marks the move on to the next digit
   always_comb begin
      state_next = state_reg;
      step       = 1'b0;
      case (state_reg)
         ACTIVE: begin
            if (tc) begin
               if (BLANK_CYCLES == 0) begin
                  state_next = ACTIVE;
                  step       = 1'b1;
               end else begin
                  state_next = BLANK;
               end
            end
         end
         BLANK: begin
            if (tc) begin
               state_next = ACTIVE;
               step       = 1'b1;
            end
         end
         default: state_next = BLANK;
      endcase
   end

   // Active-low one-hot anode for the digit currently selected
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
         assign an_sel[gi] = (idx_reg != IDX_W'(gi));
      end
   endgenerate

   // Output decode: light the selected digit only when ACTIVE and enabled
   always_comb begin
      an_next  = '1;
      seg_next = '1;
      if (state_reg == ACTIVE && active_en_reg[idx_reg]) begin
         an_next  = an_sel;
         seg_next = ~active_seg_reg[idx_reg];
      end
   end

   // Digit index advances on every step and wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg <= '0;
      end else if (step) begin
         idx_reg <= idx_reg + 1'b1;
      end
   end

   // Shadow/active buffers and the pending flag behind load_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_seg_reg <= {NUM_DIGITS{SEG_OFF}};
         shadow_en_reg  <= '0;
         active_seg_reg <= {NUM_DIGITS{SEG_OFF}};
         active_en_reg  <= '0;
         pending_reg    <= 1'b0;
      end else begin
         if (boundary && pending_reg) begin
            active_seg_reg <= shadow_seg_reg;
            active_en_reg  <= shadow_en_reg;
         end
         // An accept can only happen with pending clear, so it never races
         // the shadow->active copy; it simply arms the next boundary.
         if (accept) begin
            shadow_seg_reg <= seg_in;
            shadow_en_reg  <= en_mask;
            pending_reg    <= 1'b1;
         end else if (boundary) begin
            pending_reg    <= 1'b0;
         end
      end
   end

   // Registered display outputs and frame pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_reg         <= '1;
         seg_reg        <= '1;
         frame_done_reg <= 1'b0;
      end else begin
         an_reg         <= an_next;
         seg_reg        <= seg_next;
         frame_done_reg <= boundary;
      end
   end

   assign frame_done = frame_done_reg;
   assign AN         = an_reg;
   assign CA         = seg_reg[SEG_A];
   assign CB         = seg_reg[SEG_B];
   assign CC         = seg_reg[SEG_C];
   assign CD         = seg_reg[SEG_D];
   assign CE         = seg_reg[SEG_E];
   assign CF         = seg_reg[SEG_F];
   assign CG         = seg_reg[SEG_G];
   assign DP         = seg_reg[SEG_DP];

endmodule
